sof_detect: RTL and testbench
=============================

SOF_DETECT -- requirements
Module: sof_detect

Interface
REQ-001 SHALL have parameter SLOT_CLKS, default 16, clocks per PPM slot.
REQ-002 SHALL have parameter TOL, default 3, allowed ± clock error on every measured interval.
REQ-003 SHALL have port clk  input  1  receive clock, same rate as transmit clock (0.59 us period).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  detector enable; low forces IDLE.
REQ-006 SHALL have port ppm_in  input  1  asynchronous line input, idle-high.
REQ-007 SHALL have port sof_det  output  1  one-cycle pulse on valid start-of-frame.
REQ-008 SHALL have port sof_err  output  1  one-cycle pulse on aborted candidate.
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 SHALL synchronize ppm_in through two flops; all timing uses synchronized sample s.
REQ-011 SHALL recognise the SOF pattern: low 1 slot, high 4 slots, low 1 slot, high 2 slots.
REQ-012 SHALL use an 8-bit interval counter cnt that saturates at 255 and never wraps.
REQ-013 SHALL implement states IDLE, LOW1, GAP, LOW2, TAIL, WAIT_HI.
REQ-014 IDLE: s==0 -> LOW1, cnt=1.
REQ-015 LOW1/LOW2: s==0 increments cnt; cnt > SLOT_CLKS+TOL while low -> WAIT_HI with sof_err pulse.
REQ-016 LOW1: rising s with cnt in [SLOT_CLKS-TOL, SLOT_CLKS+TOL] -> GAP, cnt=1; otherwise -> IDLE with sof_err.
REQ-017 GAP: s==1 increments cnt; cnt > 4*SLOT_CLKS+TOL -> IDLE with sof_err.
REQ-018 GAP: falling s with cnt in [4*SLOT_CLKS-TOL, 4*SLOT_CLKS+TOL] -> LOW2, cnt=1; otherwise -> LOW1, cnt=1, with sof_err (new candidate restart).
REQ-019 LOW2: rising s with cnt in range -> TAIL, cnt=1; otherwise -> IDLE with sof_err.
REQ-020 TAIL: cnt reaching 2*SLOT_CLKS with s==1 -> pulse sof_det, -> IDLE.
REQ-021 TAIL: s==0 before that -> LOW1, cnt=1, with sof_err.
REQ-022 WAIT_HI: remain until s==1, then -> IDLE; no further sof_err.
REQ-023 sof_det and sof_err SHALL never be high in the same cycle; each is exactly one cycle wide.
REQ-024 en low SHALL force IDLE and cnt=0 next cycle, with no pulses generated; en rising resumes in IDLE.
REQ-025 sof_det SHALL assert 2 clocks (synchronizer) after the 2*SLOT_CLKS-th high sample of the tail.
REQ-026 Back-to-back SOFs SHALL be detected when the next low starts one or more cycles after the sof_det pulse.

Reset
REQ-027 On rst_n low: state=IDLE, cnt=0, synchronizer flops=1, sof_det=0, sof_err=0, busy=0.
REQ-028 Reset mid-frame SHALL abandon the candidate silently; no pulse after release until a full new pattern.

Configuration
REQ-029 With SOF_DEGLITCH_EN defined, s SHALL be the 3-sample majority of the synchronized input, adding 1 clock latency and rejecting 1-clock glitches.
REQ-030 Without SOF_DEGLITCH_EN, s SHALL be the raw 2-flop synchronizer output; all state rules unchanged.

Structure
REQ-031 Package ppm_pkg SHALL hold the FSM state enumeration, default SLOT_CLKS (16) and TOL (3).
REQ-032 Sub-module ppm_sync_filter SHALL contain the synchronizer and the optional deglitch majority filter.

Verification
REQ-033 Ideal pattern 16L/64H/16L/32H, SLOT_CLKS=16, TOL=3 -> exactly one sof_det, zero sof_err.
REQ-034 Edge widths 13L/67H/19L/32H -> sof_det; 12L first pulse -> sof_err at rising edge, no sof_det.
REQ-035 20-clock low held 40 clocks -> one sof_err at cnt=20, WAIT_HI until line high, then IDLE, no sof_det.
REQ-036 16L/30H then valid 16L/64H/16L/32H -> sof_err at 2nd falling edge, then sof_det (restart path).
REQ-037 rst_n low at GAP cnt=40, released, then full valid pattern -> no pulse before, one sof_det after.
REQ-038 SOF_DEGLITCH_EN defined, 1-clock high glitch at LOW1 cnt=8 -> still sof_det; undefined -> sof_err.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and defaults for the PPM start-of-frame detector: FSM state
// encoding, interval counter type and the nominal slot timing.
package ppm_pkg;

   localparam int unsigned SLOT_CLKS_DEF = 16;
   localparam int unsigned TOL_DEF       = 3;
   localparam int unsigned CNT_W         = 8;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW1,
      ST_GAP,
      ST_LOW2,
      ST_TAIL,
      ST_WAIT_HI
   } state_t;

   // Interval counter holds at all-ones instead of wrapping back into a window.
   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + cnt_t'(1);
   endfunction

   function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ppm_sync_filter.sv
// Two-flop synchronizer for the idle-high PPM line; with SOF_DEGLITCH_EN
// defined a 3-sample majority vote follows it to reject 1-clock glitches.
module ppm_sync_filter
   import ppm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_ppm,
   output logic o_s
);

   logic r_sync1;
   logic r_sync2;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_ppm;
         r_sync2 <= r_sync1;
      end
   end

`ifdef SOF_DEGLITCH_EN
   logic r_hist1;
   logic r_hist2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist1 <= 1'b1;
         r_hist2 <= 1'b1;
      end else begin
         r_hist1 <= r_sync2;
         r_hist2 <= r_hist1;
      end
   end

   // A level change needs two agreeing samples, so edges move one clock late.
   assign o_s = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
   assign o_s = r_sync2;
`endif

endmodule

// File: rtl/sof_detect.sv
// PPM start-of-frame detector: low 1 slot, high 4, low 1, high 2, each interval
// within +/-TOL clocks. Build option SOF_DEGLITCH_EN enables the majority filter.
module sof_detect
   import ppm_pkg::*;
#(
   parameter int unsigned SLOT_CLKS = SLOT_CLKS_DEF,
   parameter int unsigned TOL       = TOL_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic ppm_in,
   output logic sof_det,
   output logic sof_err,
   output logic busy
);

   localparam cnt_t C_SLOT_MIN = cnt_t'(SLOT_CLKS - TOL);
   localparam cnt_t C_SLOT_MAX = cnt_t'(SLOT_CLKS + TOL);
   localparam cnt_t C_GAP_MIN  = cnt_t'(4 * SLOT_CLKS - TOL);
   localparam cnt_t C_GAP_MAX  = cnt_t'(4 * SLOT_CLKS + TOL);
   localparam cnt_t C_TAIL_LEN = cnt_t'(2 * SLOT_CLKS);

   logic   w_s;
   state_t r_state;
   state_t w_state_nxt;
   cnt_t   r_cnt;
   cnt_t   w_cnt_nxt;
   cnt_t   w_cnt_inc;
   logic   r_sof_det;
   logic   r_sof_err;
   logic   w_det_nxt;
   logic   w_err_nxt;

   ppm_sync_filter u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ppm (ppm_in),
      .o_s   (w_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_sof_det <= 1'b0;
         r_sof_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sof_det <= w_det_nxt;
         r_sof_err <= w_err_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_det_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_inc   = sat_inc(r_cnt);

      if (!en) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cnt_nxt = '0;
               if (!w_s) begin
                  w_state_nxt = ST_LOW1;
                  w_cnt_nxt   = cnt_t'(1);
               end
            end

            ST_LOW1, ST_LOW2: begin
               if (!w_s) begin
                  if (w_cnt_inc > C_SLOT_MAX) begin
                     w_state_nxt = ST_WAIT_HI;
                     w_cnt_nxt   = '0;
                     w_err_nxt   = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else if (in_window(r_cnt, C_SLOT_MIN, C_SLOT_MAX)) begin
                  w_state_nxt = (r_state == ST_LOW1) ? ST_GAP : ST_TAIL;
                  w_cnt_nxt   = cnt_t'(1);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_err_nxt   = 1'b1;
               end
            end

            ST_GAP: begin
               if (w_s) begin
                  if (w_cnt_inc > C_GAP_MAX) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_err_nxt   = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  // A mistimed falling edge may itself open a new candidate.
                  w_state_nxt = in_window(r_cnt, C_GAP_MIN, C_GAP_MAX) ? ST_LOW2 : ST_LOW1;
                  w_err_nxt   = !in_window(r_cnt, C_GAP_MIN, C_GAP_MAX);
                  w_cnt_nxt   = cnt_t'(1);
               end
            end

            ST_TAIL: begin
               if (w_s) begin
                  if (w_cnt_inc == C_TAIL_LEN) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_det_nxt   = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_LOW1;
                  w_cnt_nxt   = cnt_t'(1);
                  w_err_nxt   = 1'b1;
               end
            end

            ST_WAIT_HI: begin
               w_cnt_nxt = '0;
               if (w_s) begin
                  w_state_nxt = ST_IDLE;
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign sof_det = r_sof_det;
   assign sof_err = r_sof_err;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sof_detect.sv
// Scoreboard bench for sof_detect: each scenario queues the pulses it should
// produce; a negedge monitor pops one entry per observed pulse and compares.
module tb_sof_detect;

   localparam int EV_NONE = 0;
   localparam int EV_DET  = 1;
   localparam int EV_ERR  = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic ppm_in;
   logic sof_det;
   logic sof_err;
   logic busy;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_q[$];
   string scen = "reset";
   logic  prev_det = 1'b0;
   logic  prev_err = 1'b0;

   always #5 clk = ~clk;

   sof_detect #(
      .SLOT_CLKS (16),
      .TOL       (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .ppm_in  (ppm_in),
      .sof_det (sof_det),
      .sof_err (sof_err),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d expected %0d", scen, tag, obs, exp);
      end
   endtask

   // Pulse monitor: every pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (sof_det || sof_err) begin
         int exp_ev;
         exp_ev = (exp_q.size() > 0) ? exp_q.pop_front() : EV_NONE;
         check("exclusive", 32'(sof_det & sof_err), 0);
         check("width", 32'(sof_det ? prev_det : prev_err), 0);
         check("event", sof_det ? EV_DET : EV_ERR, exp_ev);
      end
      prev_det = sof_det;
      prev_err = sof_err;
   end

   task automatic drive(input logic v, input int n);
      repeat (n) @(negedge clk) ppm_in = v;
   endtask

   task automatic frame(input int l1, input int g, input int l2, input int t);
      drive(1'b0, l1);
      drive(1'b1, g);
      drive(1'b0, l2);
      drive(1'b1, t);
   endtask

   // Let pulses drain, clear any half-matched candidate with en, then audit.
   task automatic finish_scen();
      drive(1'b1, 6);
      en = 1'b0;
      drive(1'b1, 2);
      en = 1'b1;
      drive(1'b1, 2);
      check("drained", exp_q.size(), 0);
      check("idle", 32'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b1;
      ppm_in = 1'b1;
      repeat (3) @(negedge clk);
      check("busy", 32'(busy), 0);
      check("det", 32'(sof_det), 0);
      check("err", 32'(sof_err), 0);
      rst_n = 1'b1;
      drive(1'b1, 4);

      scen = "ideal";
      exp_q.push_back(EV_DET);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "edge_widths";
      exp_q.push_back(EV_DET);
      frame(13, 67, 19, 32);
      finish_scen();

      scen = "gap61";
      exp_q.push_back(EV_DET);
      frame(16, 61, 16, 32);
      finish_scen();

      scen = "short_low";
      exp_q.push_back(EV_ERR);
      frame(12, 64, 16, 32);
      finish_scen();

      scen = "gap60";
      exp_q.push_back(EV_ERR);
      frame(16, 60, 16, 32);
      finish_scen();

      scen = "long_low";
      exp_q.push_back(EV_ERR);
      drive(1'b0, 30);
      check("wait_hi_busy", 32'(busy), 1);
      drive(1'b0, 10);
      drive(1'b1, 6);
      check("wait_hi_exit", 32'(busy), 0);
      finish_scen();

      scen = "restart";
      exp_q.push_back(EV_ERR);
      exp_q.push_back(EV_DET);
      drive(1'b0, 16);
      drive(1'b1, 30);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "tail_low";
      exp_q.push_back(EV_ERR);
      exp_q.push_back(EV_DET);
      frame(16, 64, 16, 20);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "gap_long";
      exp_q.push_back(EV_ERR);
      drive(1'b0, 16);
      drive(1'b1, 80);
      finish_scen();

      scen = "back_to_back";
      exp_q.push_back(EV_DET);
      exp_q.push_back(EV_DET);
      frame(16, 64, 16, 32);
      drive(1'b1, 3);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "en_mid";
      drive(1'b0, 16);
      drive(1'b1, 30);
      en = 1'b0;
      drive(1'b1, 4);
      en = 1'b1;
      drive(1'b1, 4);
      check("en_idle", 32'(busy), 0);
      exp_q.push_back(EV_DET);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "en_off";
      en = 1'b0;
      frame(16, 64, 16, 32);
      drive(1'b1, 6);
      check("en_off_busy", 32'(busy), 0);
      en = 1'b1;
      finish_scen();

      scen = "reset_mid";
      drive(1'b0, 16);
      drive(1'b1, 40);
      rst_n = 1'b0;
      drive(1'b1, 1);
      check("rst_busy", 32'(busy), 0);
      drive(1'b1, 2);
      rst_n = 1'b1;
      drive(1'b1, 4);
      check("rst_quiet", exp_q.size(), 0);
      exp_q.push_back(EV_DET);
      frame(16, 64, 16, 32);
      finish_scen();

      scen = "glitch";
`ifdef SOF_DEGLITCH_EN
      exp_q.push_back(EV_DET);
`else
      exp_q.push_back(EV_ERR);
      exp_q.push_back(EV_ERR);
`endif
      drive(1'b0, 8);
      drive(1'b1, 1);
      drive(1'b0, 7);
      drive(1'b1, 64);
      drive(1'b0, 16);
      drive(1'b1, 32);
      finish_scen();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
